// File: rtl/swivm_bus_responder.sv
// swivm_bus_responder: target end of the SwiVM CPU memory bus.
//
// Decodes a 64 KiB byte-addressed space into RAM plus a 256-byte MMIO window
// holding a console TX FIFO feeding an 8N1 UART transmitter and a free-running
// cycle counter. Reads are combinational; writes take effect on the rising edge.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     asynchronous active-high reset
//   i_addr    byte address (16 bits)
//   i_wrdata  write data, little-endian lanes (32 bits)
//   i_size    00=byte, 01/10=half, 11=word
//   i_we      write enable, active low
//   o_rddata  read data, zero-extended for byte/half
//   o_tx      UART serial out, idle high (registered)
//   o_txbusy  high while the transmitter is not idle
//
// Optional: define SWIVM_SIM_CONSOLE_EN to echo every accepted TXDATA byte
// with $write at the enqueue edge. Hardware behaviour is identical either way.

module swivm_bus_responder #(
    parameter int unsigned CLKS_PER_BIT    = 16,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] MMIO_BASE       = 16'hF000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_wrdata,
    input  logic [1:0]  i_size,
    input  logic        i_we,
    output logic [31:0] o_rddata,
    output logic        o_tx,
    output logic        o_txbusy
);

    localparam int unsigned FifoDepth = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_DEPTH_LOG2:0] FifoFull = (FIFO_DEPTH_LOG2 + 1)'(FifoDepth);
    localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [7:0] ram      [0:65535];
    logic [7:0] fifo_mem [0:FifoDepth-1];

    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       ovf_q, ovf_d;
    logic [31:0]                cyc_q, cyc_d;
    logic [1:0]                 state_q, state_d;
    logic [CntW-1:0]            clk_cnt_q, clk_cnt_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       tx_q, tx_d;

    // Address decode: the whole access is MMIO or RAM based on the start address.
    logic        wr, is_mmio, wr_txdata, wr_status, wr_cycles;
    logic [15:0] a1, a2, a3;
    assign wr        = ~i_we;
    assign is_mmio   = (i_addr[15:8] == MMIO_BASE[15:8]);
    assign wr_txdata = wr && is_mmio && (i_addr[7:0] == 8'h00);
    assign wr_status = wr && is_mmio && (i_addr[7:0] == 8'h04);
    assign wr_cycles = wr && is_mmio && (i_addr[7:0] == 8'h08);
    assign a1        = i_addr + 16'd1;
    assign a2        = i_addr + 16'd2;
    assign a3        = i_addr + 16'd3;

    logic fifo_empty, fifo_full, busy, deq, enq_ok, enq_drop;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FifoFull);
    assign busy       = (state_q != StIdle);
    assign deq        = (state_q == StIdle) && !fifo_empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign enq_ok     = wr_txdata && (!fifo_full || deq);
    assign enq_drop   = wr_txdata && fifo_full && !deq;

    // Read path
    always_comb begin
        o_rddata = '0;
        if (is_mmio) begin
            case (i_addr[7:0])
                8'h04:   o_rddata = {20'b0, 4'(count_q), 4'b0, ovf_q, fifo_empty, fifo_full, busy};
                8'h08:   o_rddata = cyc_q;
                default: o_rddata = '0;
            endcase
        end else begin
            case (i_size)
                2'b00:   o_rddata = {24'b0, ram[i_addr]};
                2'b11:   o_rddata = {ram[a3], ram[a2], ram[a1], ram[i_addr]};
                default: o_rddata = {16'b0, ram[a1], ram[i_addr]};
            endcase
        end
    end

    // RAM is not reset
    always_ff @(posedge i_clk) begin
        if (wr && !is_mmio) begin
            ram[i_addr] <= i_wrdata[7:0];
            if (i_size != 2'b00) ram[a1] <= i_wrdata[15:8];
            if (i_size == 2'b11) begin
                ram[a2] <= i_wrdata[23:16];
                ram[a3] <= i_wrdata[31:24];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq_ok) fifo_mem[wr_ptr_q] <= i_wrdata[7:0];
    end

    // FIFO bookkeeping and cycle counter
    always_comb begin
        wr_ptr_d = enq_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({enq_ok, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (wr_status)     ovf_d = 1'b0;
        else if (enq_drop) ovf_d = 1'b1;
        cyc_d = wr_cycles ? 32'd0 : cyc_q + 32'd1;
    end

    // Transmitter FSM; tx_d is the line level for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    shift_d   = fifo_mem[rd_ptr_q];
                    state_d   = StStart;
                    clk_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            StStart: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                    tx_d      = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cyc_q     <= '0;
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            cyc_q     <= cyc_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign o_tx     = tx_q;
    assign o_txbusy = busy;

`ifdef SWIVM_SIM_CONSOLE_EN
    always @(posedge i_clk) begin
        if (!i_rst && enq_ok) $write("%c", i_wrdata[7:0]);
    end
`else
`endif

endmodule

// File: doc/swivm_bus_responder.md
Name: swivm_bus_responder

Overview:
Target end of the SwiVM CPU memory bus. The CPU drives address, write data, size and active-low write enable; this block returns read data.
- Decodes a 64 KiB space into byte-addressed RAM plus a small MMIO window.
- The MMIO window holds a console TX FIFO with a serial 8N1 transmitter and a cycle counter.
- Sits beside the CPU core at top level and replaces the plain memory model.

Parameters:
- CLKS_PER_BIT, 16, i_clk cycles per UART bit (>=2).
- FIFO_DEPTH_LOG2, 3, log2 of TX FIFO depth (default 8 entries).
- MMIO_BASE, 16'hF000, base of 256-byte MMIO window; RAM covers all other addresses.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_addr  in  16  byte address.
- i_wrdata  in  32  write data, little-endian lanes.
- i_size  in  2  00=byte, 01/10=half, 11=word.
- i_we  in  1  write enable, active low.
- o_rddata  out  32  read data.
- o_tx  out  1  UART serial out, idle high.
- o_txbusy  out  1  high while transmitter is not IDLE.

Behaviour:
- Reset: o_tx=1, o_txbusy=0, FIFO empty, overflow flag=0, cycle counter=0, TX FSM=IDLE. RAM contents are not reset.
- Reset mid-frame aborts the frame; o_tx returns high asynchronously.
- Read path:
  - o_rddata is combinational from i_addr, i_size and current state (zero-cycle latency). The CPU registers the address on one edge and samples data on the next.
  - Bytes are read from addr, addr+1, ... and assembled little-endian; 16-bit address arithmetic wraps mod 2^16.
  - Byte and half reads are zero-extended. Unaligned accesses are legal.
- Write path:
  - Every rising edge with i_we==0 performs exactly one write of 1, 2 or 4 bytes, taken from i_wrdata[7:0], [15:0] or [31:0].
  - Writes inside the MMIO window never touch RAM.
- A whole access is MMIO when i_addr[15:8]==MMIO_BASE[15:8]. Only the low byte of the register offset is decoded; i_size is ignored for MMIO.
- MMIO map (offsets):
  - 0x00 TXDATA. Write enqueues i_wrdata[7:0]. Reads 0.
  - 0x04 STATUS. Read value:
    - bit0 txbusy
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[11:8] count
    - other bits 0
    Any write clears overflow.
  - 0x08 CYCLES. Free-running 32-bit counter, +1 per clock, wraps at 2^32. A write loads 0 on that edge; it reads 1 on the following cycle.
  - Other offsets read 0; writes to them are ignored.
- FIFO:
  - Circular buffer with count 0..2^FIFO_DEPTH_LOG2.
  - Enqueue while full: byte dropped, overflow set.
  - Simultaneous enqueue and dequeue on the same edge is allowed when not empty; count is unchanged. Enqueue while full with a dequeue on the same edge is accepted, and overflow is not set.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if FIFO not empty, pop a byte into the shift register and go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back bytes: exactly one idle cycle between the STOP end and the next START.
  - o_tx is registered.

Optional Feature:
- SWIVM_SIM_CONSOLE_EN defined: each accepted (non-dropped) TXDATA enqueue also performs $write("%c", byte) at that edge, for simulation console output.
- Undefined: no system tasks; the block is fully synthesizable.
- Hardware behaviour is identical in both cases.

Test Plan:
- Word write 0x11223344 to 0x0100 (size 11), then byte read 0x0101 -> 0x00000033; half read 0x0102 -> 0x00001122; word read 0x0100 -> 0x11223344.
- Byte write 0xAB to 0xFFFF, then word read 0xFFFE -> byte lanes from 0xFFFE, 0xFFFF, 0x0000, 0x0001 with 0xAB in bits[15:8].
- Write 0x55 to 0xF000 with CLKS_PER_BIT=4 -> o_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high; STATUS reads empty=1, busy=0 afterwards.
- Write 10 bytes to TXDATA on consecutive writes while the transmitter is busy -> the first 9 are kept (1 popped, 8 queued); the 10th is dropped with STATUS bit3=1; a write to STATUS clears bit3; all 9 bytes are transmitted in order.
- Write to 0xF008, then read it on successive cycles -> 1, 2, 3; assert i_rst for 1 cycle -> counter 0 and o_tx=1 immediately.
